// File: rtl/frame_float_sequencer.sv
// frame_float_sequencer
// Walks one frame of int16 pixel words out of the frame RAM, feeds each word
// to the shared int16_to_float converter, waits out the converter latency and
// offers the resulting float on a valid/ready stream. One word in flight.
module frame_float_sequencer #(
   parameter int PIXELS       = 768,
   parameter int ADDR_W       = 10,
   parameter int CONV_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [15:0]       ram_data,
   output logic [15:0]       conv_int,
   input  logic [31:0]       conv_float,
   output logic [31:0]       float_data,
   output logic [ADDR_W-1:0] float_index,
   output logic              float_valid,
   input  logic              float_ready
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_READ   = 3'd1;
   localparam logic [2:0] S_LATCH  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   // WAIT lasts CONV_LATENCY+1 cycles; the counter runs 0..CONV_LATENCY.
   localparam int                CNT_W     = $clog2(CONV_LATENCY + 2);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(CONV_LATENCY);
   localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(PIXELS - 1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              handshake;

   assign handshake = float_valid && float_ready;

   // Next-state and next-index decode; abort overrides everything outside IDLE.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state_nxt = S_READ;
                  idx_nxt   = '0;
               end
            end
            S_READ:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_WAIT;
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
               if (handshake) begin
                  if (idx == IDX_LAST) begin
                     state_nxt = S_DONE;
                  end else begin
                     state_nxt = S_READ;
                     idx_nxt   = idx + 1'b1;
                  end
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Control registers; status outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_rd_en <= 1'b0;
         ram_addr  <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         busy      <= (state_nxt != S_IDLE);
         done      <= (state_nxt == S_DONE);
         ram_rd_en <= (state_nxt == S_READ);
         if (state_nxt == S_READ) ram_addr <= idx_nxt;
         if (state == S_LATCH)      wait_cnt <= '0;
         else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Data registers: converter input latch and the captured output word.
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_int    <= '0;
         float_data  <= '0;
         float_index <= '0;
         float_valid <= 1'b0;
      end else begin
         if ((state == S_LATCH) && (state_nxt == S_WAIT)) conv_int <= ram_data;
         if ((state == S_WAIT) && (state_nxt == S_OUTPUT)) begin
            float_data  <= conv_float;
            float_index <= idx;
         end
         float_valid <= (state_nxt == S_OUTPUT);
      end
   end

endmodule

// File: doc/frame_float_sequencer.md
# frame_float_sequencer

Sequences conversion of one thermal frame from int16 pixel words to IEEE-754 single-precision floats. On a start request it walks the frame buffer RAM from address 0 to PIXELS-1. For each word it drives the shared `int16_to_float` converter, waits out the converter's pipeline latency, and presents the float on a valid/ready stream towards the float consumer. It sits between the sensor frame buffer and downstream float processing, and is the only block that drives the converter's input.

## Interface
- PIXELS, 768: words per frame (≥1).
- ADDR_W, 10: frame RAM address width; 2^ADDR_W ≥ PIXELS.
- CONV_LATENCY, 2: converter register stages from `int_in` to `float_out` (0 = combinational).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  synchronous cancel of frame in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- ram_rd_en  out  1  frame RAM read strobe.
- ram_addr  out  ADDR_W  frame RAM read address.
- ram_data  in  16  RAM read data; valid the cycle after `ram_rd_en`.
- conv_int  out  16  registered input to the converter, held stable while waiting.
- conv_float  in  32  converter output.
- float_data  out  32  captured float.
- float_index  out  ADDR_W  pixel index of `float_data`.
- float_valid  out  1  stream valid.
- float_ready  in  1  stream ready.

## Operation
- States: IDLE, READ, LATCH, WAIT, OUTPUT, DONE. The pixel index `idx` is ADDR_W bits.
- IDLE: if `start` and not `abort`, set `idx`=0 and go to READ.
- READ (1 cycle): `ram_rd_en`=1, `ram_addr`=`idx`. Go to LATCH.
- LATCH (1 cycle): `conv_int` <= `ram_data`. Go to WAIT and clear the wait counter.
- WAIT (CONV_LATENCY+1 cycles): `conv_int` is held. On the edge leaving WAIT:
  - `float_data` <= `conv_float`, `float_index` <= `idx`, `float_valid` <= 1.
- OUTPUT: hold `float_data`, `float_index` and `float_valid` stable until `float_valid && float_ready`. On that handshake edge:
  - `float_valid` <= 0.
  - If `idx`==PIXELS-1, go to DONE; otherwise `idx`++ and go to READ.
- DONE (1 cycle): `done`=1, `busy`=1. Go to IDLE.
- The block holds only one word in flight. `conv_int` changes only in LATCH.
- `start` outside IDLE is ignored, including in DONE. There is no queuing.
- `abort` in any non-IDLE state: the next state is IDLE and `float_valid` drops on that edge. No `done` pulse is produced. `conv_int`, `float_data` and `float_index` keep their last values.
- `abort` and `start` together in IDLE: `abort` wins and the block stays in IDLE.
- `rst` has priority over all inputs. Mid-frame it behaves like abort and additionally clears every register.
- `idx` never wraps. The last index is PIXELS-1 even when PIXELS < 2^ADDR_W.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_rd_en`=0, `ram_addr`=0, `conv_int`=0, `float_data`=0, `float_index`=0, `float_valid`=0; state IDLE.
- `start` sampled on edge S:
  - `ram_rd_en` is high in the cycle after S.
  - `conv_int` is updated on edge S+2.
  - `float_valid` rises on edge S+3+CONV_LATENCY (S+5 at the default).
- With `float_ready` held high, the per-pixel period is CONV_LATENCY+4 cycles (6 at the default).
- Frame duration with `float_ready` high: PIXELS×(CONV_LATENCY+4) cycles from edge S to the final handshake. `done` is high the cycle after the final handshake.
- Each cycle `float_ready` is low while `float_valid` is high adds exactly one cycle. No word is dropped or duplicated.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- PIXELS=4, CONV_LATENCY=2, real `int16_to_float` instance, RAM = {1253, -673, 47, -5839}, `float_ready`=1. Required response:
  - Stream 0x449CA000, 0xC4284000, 0x423C0000, 0xC5B67800 at indices 0..3.
  - First `float_valid` 5 cycles after `start`; handshakes 6 cycles apart.
  - `done` pulses once, 1 cycle after the last handshake; `busy` falls with it.
- Same frame, `float_ready` low for 7 cycles during word 1 -> `float_data`/`float_index` stable throughout; all 4 words delivered once, in order; frame 7 cycles longer.
- `start` pulsed during WAIT of word 2, and again during DONE -> ignored; exactly 4 words and one `done`. A `start` in the following IDLE cycle begins a new frame at index 0.
- `abort` asserted in OUTPUT of word 1 -> `float_valid`=0 and IDLE next cycle; no `done`. A later `start` restarts at index 0 with value 0x449CA000.
- `rst` asserted in WAIT of word 2 -> every output equals its reset value on the next cycle; `start` the following cycle is accepted normally.
- PIXELS=1, CONV_LATENCY=0, RAM = {0} -> `float_data`=0x00000000 at index 0, `float_valid` 3 cycles after `start`, `done` one cycle after the handshake.
